// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
// Shared definitions for the LED request arbiter slice.
//   state_t           : arbiter FSM states (IDLE, GRANT)
//   N_REQ             : number of requesters sharing the LED pattern FSM
//   DEFAULT_IDLE_CODE : pattern select driven while nobody holds the grant
//   onehot()          : converts a requester index into a one-hot grant word
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ = 4;

    localparam logic [N_REQ-1:0] DEFAULT_IDLE_CODE = 4'b0001;

    function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request lines starting one
// position after the last winner and returns the first active index.
//   req [3:0] in  : request lines
//   ptr [1:0] in  : index of the most recent winner
//   win [1:0] out : selected requester (0 when no request is active)
//   any       out : at least one request is active
// ---------------------------------------------------------------------------
module rr_pick
    import led_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       win,
    output logic             any
);

    logic       found;
    logic [1:0] idx;

    // Offsets 1..4 from ptr; offset 4 wraps back to ptr itself so the last
    // winner is considered only after everybody else.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_req_arbiter.sv
// ---------------------------------------------------------------------------
// led_req_arbiter
// Round-robin arbiter sharing the LED pattern FSM between four requesters.
// A grant is held for at least HOLD cycles and is preempted after MAX_HOLD
// cycles when another requester is waiting. Every release is followed by at
// least one idle cycle before the next grant.
//   clk         in  : clock, rising edge
//   rst         in  : asynchronous active-high reset
//   req   [3:0] in  : level requests
//   grant [3:0] out : one-hot current grant, 0 when idle
//   sel   [3:0] out : pattern select for led_fsm.inp (grant or IDLE_CODE)
//   busy        out : a grant is active
// ---------------------------------------------------------------------------
module led_req_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int               HOLD      = 5,
    parameter int               MAX_HOLD  = 16,
    parameter logic [N_REQ-1:0] IDLE_CODE = DEFAULT_IDLE_CODE
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] sel,
    output logic             busy
);

    localparam int             CW      = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_HOLD - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [1:0]       ptr, ptr_next;
    logic [1:0]       owner, owner_next;
    logic [N_REQ-1:0] grant_next, sel_next;
    logic             busy_next;
    logic [1:0]       pick_win;
    logic             pick_any;
    int               k;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .any (pick_any)
    );

    // All outputs are registered; ptr starts at 3 so requester 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 2'd3;
            owner <= '0;
            grant <= '0;
            sel   <= IDLE_CODE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            owner <= owner_next;
            grant <= grant_next;
            sel   <= sel_next;
            busy  <= busy_next;
        end
    end

    // k is the number of granted cycles including the current one. Release
    // always goes through IDLE, which produces the one-cycle blank between
    // consecutive grants. Only req[owner] matters during a grant, apart from
    // the preemption check on the other lines.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        owner_next = owner;
        grant_next = grant;
        sel_next   = sel;
        busy_next  = busy;
        k          = int'(cnt) + 1;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = GRANT;
                    owner_next = pick_win;
                    grant_next = onehot(pick_win);
                    sel_next   = onehot(pick_win);
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    grant_next = '0;
                    sel_next   = IDLE_CODE;
                    busy_next  = 1'b0;
                end
            end
            GRANT: begin
                if ((k >= HOLD && !req[owner]) ||
                    (k >= MAX_HOLD && |(req & ~grant))) begin
                    state_next = IDLE;
                    grant_next = '0;
                    sel_next   = IDLE_CODE;
                    busy_next  = 1'b0;
                    ptr_next   = owner;
                end else if (cnt != CNT_SAT) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
